// File: rtl/pd_fetch_queue_pkg.sv
// pd_fetch_queue_pkg: shared types, NOP constant and RV32C decompressor for the fetch queue
package pd_fetch_queue_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] instr;
    logic        illegal;
  } rvc_t;
  typedef struct packed {
    logic [31:0] instr;
    logic        illegal;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
  } pd_decode_t;
  // RV32C integer subset; floating-point compressed forms decode as illegal.
  function automatic rvc_t rvc_decompress(input logic [15:0] c);
    rvc_t        r;
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] imm6;
    logic [20:1] j;
    logic [12:1] b;
    rd   = c[11:7];
    rs2  = c[6:2];
    rdp  = {2'b01, c[4:2]};
    rs1p = {2'b01, c[9:7]};
    imm6 = {{6{c[12]}}, c[12], c[6:2]};
    j    = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};
    b    = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3]};
    r.instr   = 32'h0;
    r.illegal = 1'b0;
    case ({c[15:13], c[1:0]})
      5'b000_00: begin
        r.instr   = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, 7'h13};
        r.illegal = c[12:5] == 8'h0;
      end
      5'b010_00: r.instr = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, 7'h03};
      5'b110_00: r.instr = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, 7'h23};
      5'b000_01: r.instr = {imm6, rd, 3'b000, rd, 7'h13};
      5'b001_01: r.instr = {j[20], j[10:1], j[11], j[19:12], 5'd1, 7'h6f};
      5'b010_01: r.instr = {imm6, 5'd0, 3'b000, rd, 7'h13};
      5'b011_01: begin
        r.instr   = (rd == 5'd2) ? {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0, 5'd2, 3'b000, 5'd2, 7'h13}
                                 : {{15{c[12]}}, c[6:2], rd, 7'h37};
        r.illegal = {c[12], c[6:2]} == 6'h0;
      end
      5'b100_01: begin
        case (c[11:10])
          2'b00: r.instr = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
          2'b01: r.instr = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
          2'b10: r.instr = {imm6, rs1p, 3'b111, rs1p, 7'h13};
          default: r.instr = {(c[6:5] == 2'b00) ? 7'b0100000 : 7'b0000000, rdp, rs1p,
                              (c[6:5] == 2'b00) ? 3'b000 : (c[6:5] == 2'b01) ? 3'b100 : {1'b1, c[6:5]},
                              rs1p, 7'h33};
        endcase
        r.illegal = c[12] & (c[11:10] != 2'b10);
      end
      5'b101_01: r.instr = {j[20], j[10:1], j[11], j[19:12], 5'd0, 7'h6f};
      5'b110_01: r.instr = {b[12], b[10:5], 5'd0, rs1p, 3'b000, b[4:1], b[11], 7'h63};
      5'b111_01: r.instr = {b[12], b[10:5], 5'd0, rs1p, 3'b001, b[4:1], b[11], 7'h63};
      5'b000_10: begin
        r.instr   = {7'b0, c[6:2], rd, 3'b001, rd, 7'h13};
        r.illegal = c[12];
      end
      5'b010_10: begin
        r.instr   = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'h03};
        r.illegal = rd == 5'd0;
      end
      5'b100_10: begin
        if (!c[12]) r.instr = (rs2 == 5'd0) ? {12'b0, rd, 3'b000, 5'd0, 7'h67} : {7'b0, rs2, 5'd0, 3'b000, rd, 7'h33};
        else r.instr = (rs2 != 5'd0) ? {7'b0, rs2, rd, 3'b000, rd, 7'h33}
                     : (rd == 5'd0) ? 32'h0010_0073 : {12'b0, rd, 3'b000, 5'd1, 7'h67};
        r.illegal = ~c[12] & (rs2 == 5'd0) & (rd == 5'd0);
      end
      5'b110_10: r.instr = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, 7'h23};
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/pd_fetch_queue_if.sv
// pd_fetch_queue_if: IF-side enqueue and ID-side dequeue handshake bundle for the fetch queue
// slave: queue view (i_* in, o_* out); master: surrounding pipeline view
interface pd_fetch_queue_if #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int META_W = 64
);
  logic                    i_flush;
  logic                    i_valid;
  logic                    o_ready;
  logic [15:0]             i_raw_parcel;
  logic [31:0]             i_spanning_instr;
  logic [31:0]             i_effective_instr;
  logic                    i_sel_nop;
  logic                    i_sel_spanning;
  logic                    i_sel_compressed;
  logic [XLEN-1:0]         i_pc;
  logic [XLEN-1:0]         i_link_address;
  logic [META_W-1:0]       i_meta;
  logic                    o_valid;
  logic                    i_ready;
  logic [31:0]             o_instruction;
  logic                    o_illegal_rvc;
  logic [4:0]              o_rs1_early;
  logic [4:0]              o_rs2_early;
  logic [4:0]              o_rs3_early;
  logic [XLEN-1:0]         o_pc;
  logic [XLEN-1:0]         o_link_address;
  logic [META_W-1:0]       o_meta;
  logic [$clog2(DEPTH):0]  o_count;
  modport slave (
    input  i_flush, i_valid, i_raw_parcel, i_spanning_instr, i_effective_instr,
           i_sel_nop, i_sel_spanning, i_sel_compressed, i_pc, i_link_address, i_meta, i_ready,
    output o_ready, o_valid, o_instruction, o_illegal_rvc, o_rs1_early, o_rs2_early,
           o_rs3_early, o_pc, o_link_address, o_meta, o_count
  );
  modport master (
    output i_flush, i_valid, i_raw_parcel, i_spanning_instr, i_effective_instr,
           i_sel_nop, i_sel_spanning, i_sel_compressed, i_pc, i_link_address, i_meta, i_ready,
    input  o_ready, o_valid, o_instruction, o_illegal_rvc, o_rs1_early, o_rs2_early,
           o_rs3_early, o_pc, o_link_address, o_meta, o_count
  );
endinterface

// File: rtl/pd_fetch_queue_storage.sv
// pd_fetch_queue_storage: circular buffer with wrapping pointers, occupancy count and flush
// clk/rst_n async active-low; push/pop gated internally by full/empty; flush wins over both
module pd_fetch_queue_storage #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           push,
  input  logic           pop,
  input  logic [W-1:0]   wdata,
  output logic [W-1:0]   rdata,
  output logic [PTR_W:0] count,
  output logic           full,
  output logic           empty
);
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic             do_push, do_pop;
  assign full    = count_q == (PTR_W+1)'(DEPTH);
  assign empty   = count_q == '0;
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PTR_W'(do_pop);
    count_d  = flush ? '0 : count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/pd_fetch_queue.sv
// pd_fetch_queue: pre-decode (RVC expand + select) at enqueue, DEPTH-entry queue between IF and ID
// i_clk, i_rst_n (async active-low); bus: pd_fetch_queue_if.slave handshakes, payload and o_count
// Optional PD_QUEUE_BYPASS_EN: empty queue forwards the incoming entry to the outputs combinationally
module pd_fetch_queue
  import pd_fetch_queue_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int META_W = 64
) (
  input logic             i_clk,
  input logic             i_rst_n,
  pd_fetch_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   link;
    logic [META_W-1:0] meta;
    pd_decode_t        pd;
  } pd_queue_entry_t;
  rvc_t            rvc;
  logic [31:0]     sel_instr;
  pd_queue_entry_t enq_entry, rd_entry, head;
  logic [PTR_W:0]  count;
  logic            full, empty, bypass, push, pop, valid;
  assign rvc = rvc_decompress(bus.i_raw_parcel);
  always_comb begin
    sel_instr = bus.i_sel_nop ? NOP : bus.i_sel_spanning ? bus.i_spanning_instr
              : bus.i_sel_compressed ? rvc.instr : bus.i_effective_instr;
    enq_entry.pc   = bus.i_pc;
    enq_entry.link = bus.i_link_address;
    enq_entry.meta = bus.i_meta;
    enq_entry.pd   = '{instr: sel_instr,
                       illegal: bus.i_sel_compressed & ~bus.i_sel_nop & ~bus.i_sel_spanning & rvc.illegal,
                       rs1: sel_instr[19:15], rs2: sel_instr[24:20], rs3: sel_instr[31:27]};
  end
`ifdef PD_QUEUE_BYPASS_EN
  assign bypass = empty & bus.i_valid & ~bus.i_flush;
`else
  assign bypass = 1'b0;
`endif
  // A bypassed entry taken by ID in the same cycle never occupies a slot.
  assign push  = bus.i_valid & ~full & ~(bypass & bus.i_ready);
  assign pop   = ~empty & bus.i_ready;
  assign valid = ~empty | bypass;
  assign head  = bypass ? enq_entry : rd_entry;
  pd_fetch_queue_storage #(.DEPTH(DEPTH), .W($bits(pd_queue_entry_t))) u_storage (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .flush (bus.i_flush),
    .push  (push),
    .pop   (pop),
    .wdata (enq_entry),
    .rdata (rd_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  assign bus.o_ready        = ~full;
  assign bus.o_valid        = valid;
  assign bus.o_count        = count;
  assign bus.o_instruction  = valid ? head.pd.instr : NOP;
  assign bus.o_illegal_rvc  = valid & head.pd.illegal;
  assign bus.o_rs1_early    = valid ? head.pd.rs1 : '0;
  assign bus.o_rs2_early    = valid ? head.pd.rs2 : '0;
  assign bus.o_rs3_early    = valid ? head.pd.rs3 : '0;
  assign bus.o_pc           = valid ? head.pc : '0;
  assign bus.o_link_address = valid ? head.link : '0;
  assign bus.o_meta         = valid ? head.meta : '0;
endmodule

// File: tb/tb_pd_fetch_queue.sv
// tb_pd_fetch_queue: directed and random stimulus checked against a queue-based reference model
module tb_pd_fetch_queue;
  localparam int XLEN = 32, DEPTH = 4, META_W = 64;
  localparam logic [31:0] NOP_I = 32'h0000_0013;
  typedef struct {
    logic [31:0] instr;
    logic        ill;
    logic [31:0] pc;
    logic [31:0] link;
    logic [63:0] meta;
  } ent_t;
  typedef struct packed {
    logic [15:0] raw;
    logic [31:0] exp;
  } rvc_vec_t;
  rvc_vec_t tbl [6] = '{'{16'h0085, 32'h0010_8093}, '{16'h557D, 32'hFFF0_0513}, '{16'h85B2, 32'h00C0_05B3},
                        '{16'h40C0, 32'h0044_A403}, '{16'h908A, 32'h0020_80B3}, '{16'h8082, 32'h0000_8067}};
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  ent_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] c_exp;
  logic        c_ill;
  logic [31:0] pc;
  always #5 clk = ~clk;
  pd_fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH), .META_W(META_W)) bus ();
  pd_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .META_W(META_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_sel_nop = 1'b0;
    bus.i_sel_spanning = 1'b0;
    bus.i_sel_compressed = 1'b0;
    bus.i_raw_parcel = 16'h0;
    bus.i_spanning_instr = 32'h0;
    bus.i_effective_instr = 32'h0;
    bus.i_pc = 32'h0;
    bus.i_link_address = 32'h0;
    bus.i_meta = 64'h0;
    c_exp = 32'h0;
    c_ill = 1'b0;
  endtask
  task automatic rnd_in(input logic [31:0] p);
    int k;
    k = $urandom_range(0, 5);
    bus.i_valid = 1'b1;
    bus.i_flush = 1'b0;
    bus.i_sel_nop = $urandom_range(0, 7) == 0;
    bus.i_sel_spanning = $urandom_range(0, 3) == 0;
    bus.i_sel_compressed = $urandom_range(0, 1) == 1;
    bus.i_raw_parcel = tbl[k].raw;
    c_exp = tbl[k].exp;
    c_ill = 1'b0;
    bus.i_spanning_instr = $urandom;
    bus.i_effective_instr = $urandom;
    bus.i_pc = p;
    bus.i_link_address = p + ($urandom_range(0, 1) == 1 ? 32'd2 : 32'd4);
    bus.i_meta = {$urandom, $urandom};
  endtask
  function automatic ent_t cur();
    ent_t e;
    e.instr = bus.i_sel_nop ? NOP_I : bus.i_sel_spanning ? bus.i_spanning_instr
            : bus.i_sel_compressed ? c_exp : bus.i_effective_instr;
    e.ill = bus.i_sel_compressed && !bus.i_sel_nop && !bus.i_sel_spanning && c_ill;
    e.pc = bus.i_pc;
    e.link = bus.i_link_address;
    e.meta = bus.i_meta;
    return e;
  endfunction
  task automatic check_out(input string tag);
    ent_t e;
    logic v;
    v = q.size() != 0;
    if (v) e = q[0];
`ifdef PD_QUEUE_BYPASS_EN
    if (!v && bus.i_valid && !bus.i_flush && rst_n) begin
      v = 1'b1;
      e = cur();
    end
`endif
    if (!v) e = '{instr: NOP_I, ill: 1'b0, pc: 32'h0, link: 32'h0, meta: 64'h0};
    chk({tag, ".valid"}, 64'(bus.o_valid), 64'(v));
    chk({tag, ".ready"}, 64'(bus.o_ready), 64'(q.size() != DEPTH));
    chk({tag, ".count"}, 64'(bus.o_count), 64'(q.size()));
    if (!e.ill) begin
      chk({tag, ".instr"}, 64'(bus.o_instruction), 64'(e.instr));
      chk({tag, ".rs1"}, 64'(bus.o_rs1_early), 64'(e.instr[19:15]));
      chk({tag, ".rs2"}, 64'(bus.o_rs2_early), 64'(e.instr[24:20]));
      chk({tag, ".rs3"}, 64'(bus.o_rs3_early), 64'(e.instr[31:27]));
    end
    chk({tag, ".illegal"}, 64'(bus.o_illegal_rvc), 64'(e.ill));
    chk({tag, ".pc"}, 64'(bus.o_pc), 64'(e.pc));
    chk({tag, ".link"}, 64'(bus.o_link_address), 64'(e.link));
    chk({tag, ".meta"}, bus.o_meta, e.meta);
  endtask
  task automatic cycle(input string tag);
    int   n;
    logic take;
    #2;
    check_out(tag);
    n = q.size();
    take = 1'b0;
    if (bus.i_flush) q.delete();
    else begin
`ifdef PD_QUEUE_BYPASS_EN
      take = n == 0 && bus.i_valid && bus.i_ready;
`endif
      if (n > 0 && bus.i_ready) void'(q.pop_front());
      if (bus.i_valid && n < DEPTH && !take) q.push_back(cur());
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    idle();
    bus.i_ready = 1'b0;
    #3;
    check_out("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rnd_in(32'h100);
    bus.i_sel_nop = 1'b0;
    bus.i_sel_spanning = 1'b0;
    bus.i_sel_compressed = 1'b1;
    bus.i_raw_parcel = 16'h0085;
    c_exp = 32'h0010_8093;
    cycle("c_addi_enq");
    idle();
    #2;
    chk("c_addi.instr", 64'(bus.o_instruction), 64'h0010_8093);
    chk("c_addi.rs1", 64'(bus.o_rs1_early), 64'd1);
    chk("c_addi.rs2", 64'(bus.o_rs2_early), 64'd1);
    chk("c_addi.count", 64'(bus.o_count), 64'd1);
    cycle("c_addi_head");
    bus.i_ready = 1'b1;
    cycle("c_addi_drain");
    bus.i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rnd_in(32'h200 + 32'(4 * i));
      cycle("fill");
    end
    rnd_in(32'h210);
    cycle("full_hold0");
    cycle("full_hold1");
    bus.i_ready = 1'b1;
    cycle("full_deq");
    for (int i = 0; i < 20; i++) begin
      rnd_in(32'h210 + 32'(4 * i));
      cycle("steady");
    end
    idle();
    for (int i = 0; i < 4; i++) cycle("drain");
    bus.i_ready = 1'b0;
    rnd_in(32'h400);
    bus.i_sel_nop = 1'b0;
    bus.i_sel_spanning = 1'b0;
    bus.i_sel_compressed = 1'b1;
    bus.i_raw_parcel = 16'h0000;
    c_ill = 1'b1;
    cycle("ill_enq");
    bus.i_sel_nop = 1'b1;
    bus.i_pc = 32'h404;
    cycle("nop_enq");
    idle();
    bus.i_ready = 1'b1;
    #2;
    chk("ill.flag", 64'(bus.o_illegal_rvc), 64'd1);
    cycle("ill_head");
    #2;
    chk("nop.instr", 64'(bus.o_instruction), 64'(NOP_I));
    chk("nop.illegal", 64'(bus.o_illegal_rvc), 64'd0);
    cycle("nop_head");
    bus.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rnd_in(32'h500 + 32'(4 * i));
      cycle("pre_flush");
    end
    rnd_in(32'h50C);
    bus.i_flush = 1'b1;
    cycle("flush");
    idle();
    #2;
    chk("flush.valid", 64'(bus.o_valid), 64'd0);
    chk("flush.count", 64'(bus.o_count), 64'd0);
    chk("flush.instr", 64'(bus.o_instruction), 64'(NOP_I));
    cycle("post_flush");
    pc = 32'h1000;
    for (int i = 0; i < 300; i++) begin
      rnd_in(pc);
      pc += 32'd4;
      bus.i_valid = $urandom_range(0, 3) != 0;
      bus.i_ready = $urandom_range(0, 1) == 1;
      bus.i_flush = $urandom_range(0, 15) == 0;
      cycle("rand");
    end
    idle();
    bus.i_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rnd_in(32'h700 + 32'(4 * i));
      cycle("pre_rst");
    end
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    check_out("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rnd_in(32'h600);
    bus.i_sel_nop = 1'b0;
    bus.i_sel_spanning = 1'b0;
    bus.i_sel_compressed = 1'b0;
    bus.i_effective_instr = 32'h0050_0093;
    bus.i_ready = 1'b1;
`ifdef PD_QUEUE_BYPASS_EN
    #2;
    chk("bypass.valid", 64'(bus.o_valid), 64'd1);
    chk("bypass.instr", 64'(bus.o_instruction), 64'h0050_0093);
    chk("bypass.count", 64'(bus.o_count), 64'd0);
`endif
    cycle("bypass");
    idle();
    cycle("post_bypass");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pd_fetch_queue.md
Name: pd_fetch_queue

Overview:
- Parametrised successor to the fixed single-register pre-decode stage.
- Sits between IF and ID; performs RVC decompression and instruction selection at enqueue.
- Stores pre-decoded entries in a DEPTH-entry circular queue, decoupling fetch from decode with valid/ready handshakes.
- Flush empties the queue in one cycle; early rs1/rs2/rs3 and prediction metadata travel with each entry.

Parameters:
- XLEN, 32, PC/link width.
- DEPTH, 4, queue entries; power of two, >= 2.
- META_W, 64, opaque branch/RAS prediction metadata width, passed through unchanged.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous flush: drop all entries
- i_valid  in  1  IF entry valid
- o_ready  out  1  queue can accept (count < DEPTH)
- i_raw_parcel  in  16  compressed parcel
- i_spanning_instr  in  32  spanning 32-bit instruction
- i_effective_instr  in  32  aligned 32-bit instruction
- i_sel_nop / i_sel_spanning / i_sel_compressed  in  1 each  selection controls
- i_pc  in  XLEN  program counter
- i_link_address  in  XLEN  pc+2/pc+4
- i_meta  in  META_W  prediction metadata
- o_valid  out  1  head entry valid
- i_ready  in  1  ID accepts head
- o_instruction  out  32  selected/decompressed instruction
- o_illegal_rvc  out  1  head was compressed and illegal
- o_rs1_early / o_rs2_early / o_rs3_early  out  5 each  bits [19:15], [24:20], [31:27] of o_instruction
- o_pc / o_link_address  out  XLEN each  head PC / link
- o_meta  out  META_W  head metadata
- o_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Selection priority: sel_nop -> riscv_pkg::NOP; else sel_spanning -> spanning; else sel_compressed -> decompressed; else effective.
- Illegal flag stored = sel_compressed & ~sel_nop & ~sel_spanning & decompressor illegal.
- Enqueue when i_valid & o_ready. Dequeue when o_valid & i_ready.
- o_ready = (count != DEPTH), registered-state only; no combinational path from i_ready. When full, enqueue is refused even with a simultaneous dequeue.
- o_valid = (count != 0).
- Latency: entry enqueued in cycle N is visible at head in cycle N+1.
- Simultaneous enqueue and dequeue with 0 < count < DEPTH: count unchanged, both pointers advance.
- Pointers are PTR_W = $clog2(DEPTH) bits and wrap naturally; count is PTR_W+1 bits.
- When o_valid = 0, outputs are forced: o_instruction = NOP, rs* = 0, o_illegal_rvc = 0, o_meta = 0, o_pc = 0, o_link_address = 0.
- i_flush has priority over enqueue and dequeue: next cycle count = 0, rd_ptr = wr_ptr = 0. An enqueue attempted in the flush cycle is dropped.
- Async reset (any time, including mid-operation): count = 0, pointers = 0, o_valid = 0, o_ready = 1; storage contents are don't-care.
- Storage RAM is not reset.

Optional Feature:
- Macro: PD_QUEUE_BYPASS_EN.
- With the macro defined: when count == 0, i_valid = 1 and i_flush = 0, the incoming pre-decoded entry drives outputs combinationally with o_valid = 1.
  - If i_ready = 1 in that cycle, the entry is consumed without being written (count stays 0).
  - If i_ready = 0, it is written normally.
- Without the macro: no bypass; minimum latency is 1 cycle.

Decomposition:
- riscv_pkg gains pd_queue_entry_t (instruction, illegal, rs1/rs2/rs3, pc, link, meta) and reuses NOP.
- Existing rvc_decompressor is instantiated once on the enqueue side.
- Natural sub-module: pd_queue_storage (parametrised circular buffer with pointers/count, flush, full/empty).

Test Plan:
- Reset then enqueue raw 0x0085 with sel_compressed, PC 0x100 -> next cycle o_valid = 1, o_instruction = 0x00108093, rs1 = 1, rs2 = 1, o_count = 1.
- Enqueue 4 entries with i_ready = 0 -> o_ready = 0 after the 4th, o_count = 4. A 5th i_valid is held without a drop; drain yields PCs in FIFO order.
- Full queue, i_ready = 1 and i_valid = 1 same cycle -> dequeue only, o_count = 3. Then steady enqueue+dequeue for 20 cycles verifies pointer wrap and ordering.
- Raw 0x0000 with sel_compressed -> o_illegal_rvc = 1. The same raw with sel_nop -> o_instruction = 0x00000013, illegal = 0.
- Count 3 with i_flush and i_valid asserted -> next cycle o_valid = 0, o_count = 0, o_instruction = 0x00000013. Assert i_rst_n = 0 mid-stream -> outputs clear immediately, without waiting for a clock edge.
- PD_QUEUE_BYPASS_EN build: empty queue, i_valid and i_ready high, effective 0x00500093 -> same-cycle o_valid = 1, o_instruction = 0x00500093, o_count remains 0.
